// File: rtl/afd_pkg.sv
// Shared types and defaults for the afd sequencer: FSM state encoding and
// result-width helpers.
package afd_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_FLUSH  = 3'd2,
    S_SETTLE = 3'd3,
    S_RESULT = 3'd4
  } state_e;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_NUM_PARTITION = 1;
  // afd grows its sum by 8 bits over the sample width
  localparam int RES_PAD           = 8;
  localparam int RES_W             = DEF_WIDTH + RES_PAD;

endpackage

// File: rtl/afd_seq_addr_gen.sv
// Block/partition counters for afd_seq: shared sample-buffer address plus
// first/last-partition and last-block flags.
module afd_seq_addr_gen
  import afd_pkg::*;
#(
  parameter int NUM_PARTITION = DEF_NUM_PARTITION,
  parameter int ADDR_W        = 8,
  parameter int BLK_W         = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [BLK_W-1:0]  num_blocks_i,
  input  logic              part_inc_i,
  input  logic              blk_inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [BLK_W-1:0]  blk_o,
  output logic              first_part_o,
  output logic              last_part_o,
  output logic              last_blk_o
);

  localparam int PW = (NUM_PARTITION > 1) ? $clog2(NUM_PARTITION) : 1;

  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] nblk_q, nblk_d;
  logic [PW-1:0]    part_q, part_d;

  assign first_part_o = (part_q == '0);
  assign last_part_o  = (part_q == PW'(NUM_PARTITION - 1));
  assign last_blk_o   = (blk_q == nblk_q - BLK_W'(1));
  assign blk_o        = blk_q;

  // Truncating every operand to ADDR_W gives the wrap modulo 2^ADDR_W for free.
  assign addr_o = ADDR_W'(blk_q) * ADDR_W'(NUM_PARTITION) + ADDR_W'(part_q);

  always_comb begin
    blk_d  = blk_q;
    nblk_d = nblk_q;
    part_d = part_q;
    if (load_i) begin
      blk_d  = '0;
      part_d = '0;
      nblk_d = num_blocks_i;
    end else if (blk_inc_i) begin
      blk_d  = blk_q + BLK_W'(1);
      part_d = '0;
    end else if (part_inc_i) begin
      part_d = last_part_o ? '0 : part_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      blk_q  <= '0;
      nblk_q <= '0;
      part_q <= '0;
    end else begin
      blk_q  <= blk_d;
      nblk_q <= nblk_d;
      part_q <= part_d;
    end
  end

endmodule

// File: rtl/afd_seq.sv
// Sequencer feeding the afd accumulator from the sample buffers and returning
// per-block sums over valid/ready. Optional running minimum: AFD_SEQ_MIN_EN.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_ISSUE  | one buffer read per partition word
// S_FLUSH  | last word on afd inputs, no read
// S_SETTLE | afd sum final; captured into result regs
// S_RESULT | res_valid held until consumer accepts
module afd_seq
  import afd_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int NUM_PARTITION = DEF_NUM_PARTITION,
  parameter int ADDR_W        = 8,
  parameter int BLK_W         = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [BLK_W-1:0]         num_blocks_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     mem_rd_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic [2*WIDTH-1:0]       can_data_i,
  input  logic [2*WIDTH-1:0]       ori_data_i,
  output logic                     afd_en_o,
  output logic                     afd_acum_o,
  output logic [WIDTH-1:0]         afd_a0_o,
  output logic [WIDTH-1:0]         afd_a1_o,
  output logic [WIDTH-1:0]         afd_b0_o,
  output logic [WIDTH-1:0]         afd_b1_o,
  input  logic [WIDTH+RES_PAD-1:0] afd_result_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [WIDTH+RES_PAD-1:0] res_data_o,
  output logic [BLK_W-1:0]         res_idx_o,
  output logic [WIDTH+RES_PAD-1:0] best_val_o,
  output logic [BLK_W-1:0]         best_idx_o
);

  localparam int RW = WIDTH + RES_PAD;

  state_e state_q, state_d;

  logic              done_q, done_d;
  logic              afd_en_q, afd_acum_q;
  logic [RW-1:0]     res_data_q;
  logic [BLK_W-1:0]  res_idx_q;
  logic              mem_rd;
  logic              load, part_inc, blk_inc;
  logic [ADDR_W-1:0] addr;
  logic [BLK_W-1:0]  blk;
  logic              first_part, last_part, last_blk;
  logic              res_hs;

  afd_seq_addr_gen #(
    .NUM_PARTITION (NUM_PARTITION),
    .ADDR_W        (ADDR_W),
    .BLK_W         (BLK_W)
  ) u_addr_gen (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (load),
    .num_blocks_i (num_blocks_i),
    .part_inc_i   (part_inc),
    .blk_inc_i    (blk_inc),
    .addr_o       (addr),
    .blk_o        (blk),
    .first_part_o (first_part),
    .last_part_o  (last_part),
    .last_blk_o   (last_blk)
  );

  assign res_hs = (state_q == S_RESULT) && res_ready_i;

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    load     = 1'b0;
    part_inc = 1'b0;
    blk_inc  = 1'b0;
    mem_rd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (num_blocks_i != '0) begin
            load    = 1'b1;
            state_d = S_ISSUE;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        mem_rd   = 1'b1;
        part_inc = 1'b1;
        if (last_part) state_d = S_FLUSH;
      end
      S_FLUSH:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_RESULT;
      S_RESULT: begin
        if (res_ready_i) begin
          if (last_blk) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            blk_inc = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      afd_en_q   <= 1'b0;
      afd_acum_q <= 1'b0;
      res_data_q <= '0;
      res_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      afd_en_q   <= mem_rd;
      // acum tracks the word being read so the first word of a block restarts the sum
      afd_acum_q <= mem_rd & ~first_part;
      if (state_q == S_SETTLE) begin
        res_data_q <= afd_result_i;
        res_idx_q  <= blk;
      end
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign mem_rd_o    = mem_rd;
  assign mem_addr_o  = mem_rd ? addr : '0;
  assign afd_en_o    = afd_en_q;
  assign afd_acum_o  = afd_acum_q;
  assign afd_a0_o    = afd_en_q ? can_data_i[WIDTH-1:0]       : '0;
  assign afd_a1_o    = afd_en_q ? can_data_i[2*WIDTH-1:WIDTH] : '0;
  assign afd_b0_o    = afd_en_q ? ori_data_i[WIDTH-1:0]       : '0;
  assign afd_b1_o    = afd_en_q ? ori_data_i[2*WIDTH-1:WIDTH] : '0;
  assign res_valid_o = (state_q == S_RESULT);
  assign res_data_o  = res_data_q;
  assign res_idx_o   = res_idx_q;

`ifdef AFD_SEQ_MIN_EN
  logic [RW-1:0]    best_val_q;
  logic [BLK_W-1:0] best_idx_q;

  // Strict less-than keeps the earlier block on ties.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      best_val_q <= '0;
      best_idx_q <= '0;
    end else if (res_hs && ((res_idx_q == '0) || (res_data_q < best_val_q))) begin
      best_val_q <= res_data_q;
      best_idx_q <= res_idx_q;
    end
  end

  assign best_val_o = best_val_q;
  assign best_idx_o = best_idx_q;
`else
  logic unused_hs;
  assign unused_hs  = res_hs;
  assign best_val_o = '0;
  assign best_idx_o = '0;
`endif

endmodule

// File: tb/tb_afd_seq.sv
// Self-checking bench for afd_seq with behavioural sample buffers, afd model
// and a per-run reference of addresses, operands, sums and best match.
module tb_afd_seq;

  localparam int WIDTH  = 8;
  localparam int NP     = 4;
  localparam int ADDR_W = 8;
  localparam int BLK_W  = 8;
  localparam int RW     = WIDTH + 8;
  localparam int LAT    = NP + 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst, start, res_ready;
  logic [BLK_W-1:0]  num_blocks;
  logic              busy, done, mem_rd, afd_en, afd_acum, res_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [2*WIDTH-1:0] can_data, ori_data;
  logic [WIDTH-1:0]  afd_a0, afd_a1, afd_b0, afd_b1;
  logic [RW-1:0]     afd_sum, res_data, best_val;
  logic [BLK_W-1:0]  res_idx, best_idx;

  logic [2*WIDTH-1:0] can_mem [DEPTH];
  logic [2*WIDTH-1:0] ori_mem [DEPTH];

  int addr_q[$];
  logic [4*WIDTH:0] op_q[$];
  logic [RW+BLK_W-1:0] res_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, start_cyc = 0, last_rise = 0, hs_cyc = 0, zs_cyc = 0;
  bit want_first = 0, nostall = 0, zero_start = 0;
  bit prev_valid = 0, prev_ready = 0;
  logic [RW-1:0]    prev_data = '0;
  logic [BLK_W-1:0] prev_idx = '0;

  always #5 clk = ~clk;

  afd_seq #(.WIDTH(WIDTH), .NUM_PARTITION(NP), .ADDR_W(ADDR_W), .BLK_W(BLK_W)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_blocks_i(num_blocks),
    .busy_o(busy), .done_o(done), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
    .can_data_i(can_data), .ori_data_i(ori_data),
    .afd_en_o(afd_en), .afd_acum_o(afd_acum),
    .afd_a0_o(afd_a0), .afd_a1_o(afd_a1), .afd_b0_o(afd_b0), .afd_b1_o(afd_b1),
    .afd_result_i(afd_sum), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_idx_o(res_idx),
    .best_val_o(best_val), .best_idx_o(best_idx)
  );

  function automatic int ad(input int x, input int y);
    return (x > y) ? x - y : y - x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // synchronous-read sample buffers
  always @(posedge clk) begin
    if (mem_rd) begin
      can_data <= can_mem[mem_addr];
      ori_data <= ori_mem[mem_addr];
    end
  end

  // afd: registered sum of absolute differences, restarted when acum is low
  always @(posedge clk) begin
    if (!rst) afd_sum <= '0;
    else if (afd_en)
      afd_sum <= RW'((afd_acum ? int'(afd_sum) : 0)
                     + ad(int'(afd_a0), int'(afd_b0)) + ad(int'(afd_a1), int'(afd_b1)));
  end

  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      if (mem_rd) addr_q.push_back(int'(mem_addr));
      if (afd_en) op_q.push_back({afd_acum, afd_a1, afd_a0, afd_b1, afd_b0});
      if (res_valid) chk("no_read_in_result", mem_rd, 0);
      if (prev_valid && !prev_ready) begin
        chk("stall_valid", res_valid, 1);
        chk("stall_data", res_data, prev_data);
        chk("stall_idx", res_idx, prev_idx);
      end
      if (res_valid && !prev_valid) begin
        if (want_first) chk("first_latency", cyc - start_cyc, LAT);
        else if (nostall) chk("block_period", cyc - last_rise, LAT);
        want_first = 0;
        last_rise = cyc;
      end
      if (done) begin
        if (zero_start) chk("done_zero_blocks", cyc - zs_cyc, 1);
        else chk("done_after_handshake", cyc - hs_cyc, 1);
        zero_start = 0;
      end
      if (res_valid && res_ready) begin
        res_q.push_back({res_idx, res_data});
        hs_cyc = cyc;
      end
      if (start && !busy) begin
        if (num_blocks != '0) begin start_cyc = cyc; want_first = 1; end
        else begin zs_cyc = cyc; zero_start = 1; end
      end
    end
    prev_valid = res_valid;
    prev_ready = res_ready;
    prev_data  = res_data;
    prev_idx   = res_idx;
  end

  task automatic randomize_mem();
    for (int i = 0; i < DEPTH; i++) begin
      can_mem[i] = 16'($urandom);
      ori_mem[i] = 16'($urandom);
    end
  endtask

  task automatic launch(input int nb);
    addr_q.delete(); op_q.delete(); res_q.delete();
    start = 1'b1;
    num_blocks = BLK_W'(nb);
    @(negedge clk);
    start = 1'b0;
    num_blocks = BLK_W'($urandom);
  endtask

  task automatic wait_done(input int pct, input bit poke);
    int budget = 4000;
    while (!done && budget > 0) begin
      res_ready = ($urandom_range(99) < pct);
      start = poke && (budget % 7 == 0);
      num_blocks = BLK_W'($urandom);
      @(negedge clk);
      budget--;
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_run", busy, 0);
  endtask

  task automatic verify(input int nb);
    int a, i, s;
    logic [RW-1:0] bv;
    int bi;
    bv = '0; bi = 0;
    chk("n_results", res_q.size(), nb);
    chk("n_reads", addr_q.size(), nb * NP);
    chk("n_words", op_q.size(), nb * NP);
    for (int b = 0; b < nb; b++) begin
      s = 0;
      for (int p = 0; p < NP; p++) begin
        i = b * NP + p;
        a = i % DEPTH;
        s += ad(int'(can_mem[a][7:0]), int'(ori_mem[a][7:0]))
           + ad(int'(can_mem[a][15:8]), int'(ori_mem[a][15:8]));
        if (i < addr_q.size()) chk("mem_addr", addr_q[i], a);
        if (i < op_q.size()) chk("afd_operands", op_q[i], {p != 0, can_mem[a], ori_mem[a]});
      end
      if (b < res_q.size()) chk("block_result", res_q[b], {BLK_W'(b), RW'(s)});
      if (b == 0 || RW'(s) < bv) begin bv = RW'(s); bi = b; end
    end
`ifdef AFD_SEQ_MIN_EN
    chk("best_val", best_val, bv);
    chk("best_idx", best_idx, bi);
`else
    chk("best_val_tied", best_val, 0);
    chk("best_idx_tied", best_idx, 0);
`endif
  endtask

  initial begin
    int vals[4];
    rst = 1'b0; start = 1'b0; res_ready = 1'b0; num_blocks = '0;
    randomize_mem();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem", {mem_rd, mem_addr}, 0);
    chk("rst_afd", {afd_en, afd_acum, afd_a0, afd_a1, afd_b0, afd_b1}, 0);
    chk("rst_res", {res_valid, res_idx, res_data}, 0);
    chk("rst_best", {best_val, best_idx}, 0);
    rst = 1'b1;
    @(negedge clk);

    // single block with known operands; remaining words contribute nothing
    can_mem[0] = {8'd20, 8'd10};
    ori_mem[0] = {8'd15, 8'd13};
    for (int i = 1; i < NP; i++) ori_mem[i] = can_mem[i];
    nostall = 1;
    launch(1);
    wait_done(100, 0);
    verify(1);
    if (op_q.size() > 0) chk("t1_operands", op_q[0], {1'b0, 8'd20, 8'd10, 8'd15, 8'd13});
    if (res_q.size() > 0) chk("t1_result", res_q[0], {8'd0, 16'd8});

    // best-match pattern 30,12,12,40
    vals = '{30, 12, 12, 40};
    for (int b = 0; b < 4; b++) begin
      can_mem[b*NP] = {8'd0, 8'(vals[b])};
      ori_mem[b*NP] = 16'd0;
      for (int p = 1; p < NP; p++) ori_mem[b*NP+p] = can_mem[b*NP+p];
    end
    launch(4);
    wait_done(100, 0);
    verify(4);
    if (res_q.size() > 2) chk("pattern_res2", res_q[2], {8'd2, 16'd12});
`ifdef AFD_SEQ_MIN_EN
    chk("pattern_best", {best_idx, best_val}, {8'd1, 16'd12});
`endif

    // backpressure: hold ready low 10 cycles in RESULT, poke start meanwhile
    randomize_mem();
    nostall = 0;
    res_ready = 1'b0;
    launch(2);
    for (int k = 0; k < 40 && !res_valid; k++) @(negedge clk);
    chk("stall_reached_result", res_valid, 1);
    for (int k = 0; k < 10; k++) begin
      start = 1'b1;
      num_blocks = 8'd9;
      @(negedge clk);
    end
    start = 1'b0;
    chk("stall_still_valid", res_valid, 1);
    chk("stall_no_read", mem_rd, 0);
    wait_done(100, 0);
    verify(2);

    // zero-block run
    addr_q.delete();
    start = 1'b1;
    num_blocks = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_clear", done, 0);
    chk("zero_no_reads", addr_q.size(), 0);

    // reset while issuing reads
    launch(3);
    @(negedge clk);
    chk("mid_issue_reading", mem_rd, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", {busy, done, mem_rd, mem_addr, afd_en, afd_acum}, 0);
    chk("midrst_res", {res_valid, res_data, res_idx}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_no_done", {done, busy}, 0);

    // randomized runs with random backpressure and start pokes while busy
    for (int r = 0; r < 4; r++) begin
      randomize_mem();
      launch($urandom_range(1, 6));
      wait_done($urandom_range(30, 90), 1);
      verify(res_q.size() > 0 ? int'(res_q[res_q.size()-1][RW+BLK_W-1:RW]) + 1 : 1);
    end

    // zero-stall run long enough to wrap the address space
    randomize_mem();
    nostall = 1;
    launch(70);
    wait_done(100, 0);
    verify(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/afd_seq.md
Name: afd_seq

Overview:
- Upstream sequencer for the afd absolute-difference accumulator.
- Reads paired candidate and original samples from two synchronous-read sample buffers.
- Drives afd's en/acum/a0/a1/b0/b1 with NUM_PARTITION words per block, waits for afd's registered sum to settle, and returns each block's result over a valid/ready handshake.
- Sits between the sample buffers and afd; its result port feeds the best-match logic.

Parameters:
WIDTH, 8, sample width; afd result width is WIDTH+8
NUM_PARTITION, 1, words (sample pairs) accumulated per block, >=1
ADDR_W, 8, sample-buffer word address width
BLK_W, 8, width of block count/index

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; launch run (ignored unless IDLE)
num_blocks  in  BLK_W  blocks in run; sampled on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on return to IDLE after run
mem_rd  out  1  read strobe to both sample buffers
mem_addr  out  ADDR_W  word address, shared by both buffers
can_data  in  2*WIDTH  candidate pair {s1,s0}, valid cycle after mem_rd
ori_data  in  2*WIDTH  original pair {s1,s0}, valid cycle after mem_rd
afd_en  out  1  to afd en
afd_acum  out  1  to afd acum
afd_a0, afd_a1  out  WIDTH  candidate s0/s1 to afd
afd_b0, afd_b1  out  WIDTH  original s0/s1 to afd
afd_result  in  WIDTH+8  afd out_afd
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  WIDTH+8  captured block sum
res_idx  out  BLK_W  block index of res_data

Behaviour:
- Reset (rst==0 at posedge): state IDLE; every output 0; counters cleared. Reset mid-run abandons the run; no done pulse.
- States: IDLE, ISSUE, FLUSH, SETTLE, RESULT.
- IDLE: start=1 and num_blocks>0 -> ISSUE, blk=0, part=0. start=1 and num_blocks==0 -> done pulse next cycle, stay IDLE.
- ISSUE: mem_rd=1, mem_addr=(blk*NUM_PARTITION+part) mod 2^ADDR_W, part++. After part==NUM_PARTITION-1 -> FLUSH.
- Read pipeline: afd_en is mem_rd delayed one cycle. Operands forward combinationally from can_data/ori_data (a0=can[WIDTH-1:0], a1=can[2W-1:W], same mapping for b from ori). afd_acum=0 for the part==0 word, 1 for all others. Operands are 0 when afd_en=0.
- FLUSH: last word presented to afd (afd_en=1); mem_rd=0.
- SETTLE: afd_en=0. afd_result now holds the final sum. At the closing edge: capture res_data<=afd_result, res_idx<=blk. -> RESULT.
- RESULT: res_valid=1; res_data/res_idx held stable. On res_valid&&res_ready: res_valid=0 next cycle. Then blk==num_blocks-1 -> IDLE with done pulse; else blk++, part=0 -> ISSUE.
- Latency: start accepted at edge e0 -> res_valid first high P+3 cycles later (P=NUM_PARTITION). Zero-stall block period is P+3 cycles.
- Backpressure: res_ready low stalls in RESULT indefinitely; no reads are issued while stalled.
- start during busy: ignored, num_blocks not resampled.
- Address wraps silently past 2^ADDR_W-1.

Optional Feature:
- AFD_SEQ_MIN_EN: adds outputs best_val (WIDTH+8) and best_idx (BLK_W).
- With the macro: each handshake updates the pair if the result is strictly less, or it is block 0 of the run. Ties keep the earlier index. Values are stable from the done pulse until the next accepted start.
- Without the macro: the ports exist and are tied to 0.

Decomposition:
- Shared package afd_pkg: state enum (IDLE..RESULT); localparam RES_W=WIDTH+8; default WIDTH/NUM_PARTITION.
- One sub-module, afd_seq_addr_gen: blk/part counters, address multiply-add, last-part and last-block flags.
- FSM, read pipeline and result registers stay in afd_seq.

Test Plan:
- P=1, num_blocks=1, can word {20,10}, ori word {15,13}, res_ready=1 -> mem_addr=0; afd driven a0=10,a1=20,b0=13,b1=15 with acum=0; res_data=8, res_idx=0 at start+4 cycles; done pulse next cycle.
- P=4, num_blocks=2 -> mem_addr 0..3 then 4..7; acum sequence 0,1,1,1 per block; two results, idx 0 then 1.
- res_ready held low 10 cycles in RESULT -> res_valid and res_data stable, mem_rd stays 0, then resumes.
- num_blocks=0 start -> no mem_rd, done one cycle later; start pulsed while busy -> ignored.
- rst=0 asserted during ISSUE -> next cycle all outputs 0, IDLE, no done; new start runs cleanly.
- AFD_SEQ_MIN_EN, block results 30,12,12,40 -> best_val=12, best_idx=1.
